// File: rtl/alu_operand_arbiter.sv
// Round-robin packet arbiter for the shared operand mux. It grants one requester per whole packet.
// There is a 1-cycle arbitration bubble per packet and 1-cycle data latency. Readies depend only on registered state, y_ready and rst.
module alu_operand_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             g_valid,
  input  logic [WIDTH-1:0] g_data,
  input  logic             g_last,
  output logic             g_ready,
  input  logic             h_valid,
  input  logic [WIDTH-1:0] h_data,
  input  logic             h_last,
  output logic             h_ready,
  output logic             Op,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  input  logic             y_ready
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic             y_valid_q, y_valid_d;
  logic             y_last_q, y_last_d;
  logic [WIDTH-1:0] y_data_q, y_data_d;

  logic             out_free;
  logic             own_ready;
  logic             own_valid;
  logic             own_last;
  logic [WIDTH-1:0] own_data;
  logic             xfer;
  logic             winner;

  // Ready never looks at any valid input, so the requesters see no combinational loop.
  always_comb begin
    out_free  = !y_valid_q || y_ready;
    own_ready = (state_q == OWN) && out_free && !rst;
    own_valid = owner_q ? h_valid : g_valid;
    own_data  = owner_q ? h_data  : g_data;
    own_last  = owner_q ? h_last  : g_last;
    xfer      = own_valid && own_ready;
    winner    = (g_valid && h_valid) ? prio_q : h_valid;
  end

  assign g_ready = own_ready && !owner_q;
  assign h_ready = own_ready &&  owner_q;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    prio_d    = prio_q;
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;

    if (y_valid_q && y_ready) begin
      y_valid_d = 1'b0;
    end

    if (state_q == IDLE) begin
      if (g_valid || h_valid) begin
        owner_d = winner;
        state_d = OWN;
      end
    end else if (xfer) begin
      y_valid_d = 1'b1;
      y_data_d  = own_data;
      y_last_d  = own_last;
      if (own_last) begin
        state_d = IDLE;
        prio_d  = ~owner_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      prio_q    <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      y_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      prio_q    <= prio_d;
      y_valid_q <= y_valid_d;
      y_data_q  <= y_data_d;
      y_last_q  <= y_last_d;
    end
  end

  assign Op      = owner_q;
  assign y_valid = y_valid_q;
  assign y_data  = y_data_q;
  assign y_last  = y_last_q;

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// Bench for alu_operand_arbiter: directed scenarios plus a randomized packet stream checked against a packet-order model.
module tb_alu_operand_arbiter;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         g_valid, g_last, g_ready;
  logic [W-1:0] g_data;
  logic         h_valid, h_last, h_ready;
  logic [W-1:0] h_data;
  logic         Op;
  logic         y_valid, y_last, y_ready;
  logic [W-1:0] y_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_operand_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .g_valid(g_valid), .g_data(g_data), .g_last(g_last), .g_ready(g_ready),
    .h_valid(h_valid), .h_data(h_data), .h_last(h_last), .h_ready(h_ready),
    .Op(Op), .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready)
  );

  task automatic clr_inputs();
    g_valid = 1'b0; g_data = '0; g_last = 1'b0;
    h_valid = 1'b0; h_data = '0; h_last = 1'b0;
    y_ready = 1'b1;
  endtask

  // Leaves the caller at a falling edge with rst just released (cycle t0).
  task automatic do_reset();
    @(negedge clk);
    clr_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; y_ready = 1'b1;
    g_valid = 1'b1; g_data = 8'h5A; g_last = 1'b1;
    h_valid = 1'b1; h_data = 8'h6B; h_last = 1'b1;
    #1;
    checks++; if ((g_ready | h_ready) !== 1'b0) begin errors++; $display("FAIL rst_ready_pre got g=%b h=%b exp 0", g_ready, h_ready); end
    @(posedge clk); #1;
    checks++; if (Op !== 1'b0) begin errors++; $display("FAIL rst_op got %b exp 0", Op); end
    checks++; if (y_valid !== 1'b0) begin errors++; $display("FAIL rst_y_valid got %b exp 0", y_valid); end
    checks++; if ({y_last, y_data} !== 9'h0) begin errors++; $display("FAIL rst_y_data got %h exp 0", {y_last, y_data}); end
    checks++; if ((g_ready | h_ready) !== 1'b0) begin errors++; $display("FAIL rst_ready got g=%b h=%b exp 0", g_ready, h_ready); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (g_ready !== 1'b0) begin errors++; $display("FAIL rst_idle_ready got %b exp 0", g_ready); end
    @(negedge clk); #1;
    checks++; if ({Op, g_ready, h_ready} !== 3'b010) begin errors++; $display("FAIL rst_first_grant got op/g/h=%b exp 010", {Op, g_ready, h_ready}); end
    @(negedge clk); g_valid = 1'b0; #1;
    checks++; if ({y_valid, y_last, y_data} !== {2'b11, 8'h5A}) begin errors++; $display("FAIL rst_first_beat got %h exp 35a", {y_valid, y_last, y_data}); end
  endtask

  task automatic test_single_g();
    logic [7:0] beats [3];
    int bi;
    logic exp_v, exp_r;
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    bi = 0;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      if (bi < 3) begin g_valid = 1'b1; g_data = beats[bi]; g_last = (bi == 2); end
      else begin g_valid = 1'b0; g_last = 1'b0; end
      #1;
      exp_v = (k >= 2 && k <= 4);
      exp_r = (k >= 1 && k <= 3);
      checks++; if (y_valid !== exp_v) begin errors++; $display("FAIL single_y_valid k=%0d got %b exp %b", k, y_valid, exp_v); end
      if (exp_v) begin
        checks++; if ({y_last, y_data} !== {(k == 4), beats[k-2]}) begin errors++; $display("FAIL single_y_data k=%0d got %h exp %h", k, {y_last, y_data}, {(k == 4), beats[k-2]}); end
      end
      checks++; if (g_ready !== exp_r) begin errors++; $display("FAIL single_g_ready k=%0d got %b exp %b", k, g_ready, exp_r); end
      if (g_valid && g_ready) bi++;
    end
  endtask

  task automatic test_round_robin();
    int gi, hi, ph, pk;
    logic exp_v, exp_op;
    logic [7:0] exp_d;
    gi = 0; hi = 0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      g_valid = 1'b1; g_data = 8'(8'hA0 + gi); g_last = (gi == 1);
      h_valid = 1'b1; h_data = 8'(8'hB0 + hi); h_last = (hi == 1);
      #1;
      if (k >= 1) begin
        exp_op = (((k - 1) / 3) % 2) == 1;
        checks++; if (Op !== exp_op) begin errors++; $display("FAIL rr_op k=%0d got %b exp %b", k, Op, exp_op); end
      end
      if (k >= 2) begin
        ph = (k - 2) % 3; pk = (k - 2) / 3;
        exp_v = (ph != 2);
        exp_d = 8'(((pk % 2) == 1 ? 8'hB0 : 8'hA0) + ph);
        checks++; if (y_valid !== exp_v) begin errors++; $display("FAIL rr_y_valid k=%0d got %b exp %b", k, y_valid, exp_v); end
        if (exp_v) begin
          checks++; if ({y_last, y_data} !== {(ph == 1), exp_d}) begin errors++; $display("FAIL rr_y_data k=%0d got %h exp %h", k, {y_last, y_data}, {(ph == 1), exp_d}); end
        end
      end
      if (g_valid && g_ready) gi ^= 1;
      if (h_valid && h_ready) hi ^= 1;
    end
  endtask

  task automatic test_backpressure();
    int bi;
    logic [8:0] got [$];
    bi = 0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      if (bi < 6) begin g_valid = 1'b1; g_data = 8'(8'h40 + bi); g_last = (bi == 5); end
      else begin g_valid = 1'b0; g_last = 1'b0; end
      y_ready = !(k >= 4 && k <= 7);
      #1;
      if (k >= 4 && k <= 7) begin
        checks++; if ({y_valid, y_data} !== {1'b1, 8'h42}) begin errors++; $display("FAIL bp_hold k=%0d got %h exp 142", k, {y_valid, y_data}); end
        checks++; if (g_ready !== 1'b0) begin errors++; $display("FAIL bp_ready k=%0d got %b exp 0", k, g_ready); end
      end
      if (y_valid && y_ready) got.push_back({y_last, y_data});
      if (g_valid && g_ready) bi++;
    end
    y_ready = 1'b1;
    checks++; if (got.size() != 6) begin errors++; $display("FAIL bp_count got %0d exp 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      checks++; if (got[i] !== {(i == 5), 8'(8'h40 + i)}) begin errors++; $display("FAIL bp_order i=%0d got %h exp %h", i, got[i], {(i == 5), 8'(8'h40 + i)}); end
    end
  endtask

  task automatic test_owner_stall();
    int hi, s, k_last;
    logic h_done, g_done;
    logic [8:0] got [$];
    hi = 0; s = 0; k_last = -1; h_done = 1'b0; g_done = 1'b0;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      g_valid = (k >= 1) && !g_done; g_data = 8'hD0; g_last = 1'b1;
      h_valid = (hi < 4) && !(hi == 2 && s < 3);
      h_data = 8'(8'hC0 + hi); h_last = (hi == 3);
      if (hi == 2 && s < 3) s++;
      #1;
      if (!h_done && k >= 1) begin
        checks++; if ({Op, g_ready} !== 2'b10) begin errors++; $display("FAIL stall_hold k=%0d got op/g=%b exp 10", k, {Op, g_ready}); end
      end
      if (k_last >= 0 && k == k_last + 1) begin
        checks++; if (g_ready !== 1'b0) begin errors++; $display("FAIL stall_bubble k=%0d got %b exp 0", k, g_ready); end
      end
      if (k_last >= 0 && k == k_last + 2) begin
        checks++; if ({Op, g_ready} !== 2'b01) begin errors++; $display("FAIL stall_g_win k=%0d got op/g=%b exp 01", k, {Op, g_ready}); end
      end
      if (y_valid && y_ready) got.push_back({y_last, y_data});
      if (g_valid && g_ready) g_done = 1'b1;
      if (h_valid && h_ready) begin
        if (hi == 3) begin h_done = 1'b1; k_last = k; end
        hi++;
      end
    end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL stall_count got %0d exp 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      logic [8:0] e;
      e = (i < 4) ? {(i == 3), 8'(8'hC0 + i)} : 9'h1D0;
      checks++; if (got[i] !== e) begin errors++; $display("FAIL stall_order i=%0d got %h exp %h", i, got[i], e); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    g_valid = 1'b1; g_data = 8'h70; g_last = 1'b0;
    @(negedge clk); #1;
    checks++; if (g_ready !== 1'b1) begin errors++; $display("FAIL rmid_rdy1 got %b exp 1", g_ready); end
    @(negedge clk); g_data = 8'h71; #1;
    checks++; if (g_ready !== 1'b1) begin errors++; $display("FAIL rmid_rdy2 got %b exp 1", g_ready); end
    @(negedge clk); g_data = 8'h72; rst = 1'b1; #1;
    checks++; if ({y_valid, y_data} !== 9'h171) begin errors++; $display("FAIL rmid_beat2 got %h exp 171", {y_valid, y_data}); end
    @(negedge clk); rst = 1'b0; g_valid = 1'b0;
    h_valid = 1'b1; h_data = 8'h99; h_last = 1'b1; #1;
    checks++; if ({y_valid, Op, h_ready} !== 3'b000) begin errors++; $display("FAIL rmid_cleared got v/op/h=%b exp 000", {y_valid, Op, h_ready}); end
    @(negedge clk); #1;
    checks++; if ({Op, h_ready, g_ready} !== 3'b110) begin errors++; $display("FAIL rmid_h_win got op/h/g=%b exp 110", {Op, h_ready, g_ready}); end
    @(negedge clk); h_valid = 1'b0; #1;
    checks++; if ({y_valid, y_last, y_data} !== {2'b11, 8'h99}) begin errors++; $display("FAIL rmid_h_beat got %h exp 399", {y_valid, y_last, y_data}); end
  endtask

  task automatic test_random();
    localparam int NP = 16;
    logic [8:0] gb [$];
    logic [8:0] hb [$];
    logic [8:0] exp_q [$];
    logic [8:0] e;
    int gpos, hpos, total, seen, len, k;
    gpos = 0; hpos = 0; seen = 0;
    for (int p = 0; p < NP; p++) begin
      for (int src = 0; src < 2; src++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          e = {(b == len - 1), 8'($urandom)};
          if (src == 0) gb.push_back(e); else hb.push_back(e);
          exp_q.push_back(e);
        end
      end
    end
    total = exp_q.size();
    do_reset();
    k = 0;
    while (seen < total && k < 3000) begin
      if (k > 0) @(negedge clk);
      if (gpos < gb.size()) begin
        g_data = gb[gpos][7:0]; g_last = gb[gpos][8];
        g_valid = !(gpos > 0 && !gb[gpos-1][8] && $urandom_range(0, 3) == 0);
      end else g_valid = 1'b0;
      if (hpos < hb.size()) begin
        h_data = hb[hpos][7:0]; h_last = hb[hpos][8];
        h_valid = !(hpos > 0 && !hb[hpos-1][8] && $urandom_range(0, 3) == 0);
      end else h_valid = 1'b0;
      y_ready = ($urandom_range(0, 3) != 0);
      #1;
      checks++; if ((g_ready & h_ready) !== 1'b0) begin errors++; $display("FAIL rnd_both_ready k=%0d got 1 exp 0", k); end
      if (y_valid && y_ready) begin
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra k=%0d got %h exp none", k, {y_last, y_data});
        end else begin
          e = exp_q.pop_front();
          checks++; if ({y_last, y_data} !== e) begin errors++; $display("FAIL rnd_beat n=%0d got %h exp %h", seen, {y_last, y_data}, e); end
        end
        seen++;
      end
      if (g_valid && g_ready) gpos++;
      if (h_valid && h_ready) hpos++;
      k++;
    end
    checks++; if (seen != total) begin errors++; $display("FAIL rnd_timeout got %0d beats exp %0d", seen, total); end
    clr_inputs();
  endtask

  initial begin
    clr_inputs();
    rst = 1'b0;
    test_reset();
    test_single_g();
    test_round_robin();
    test_backpressure();
    test_owner_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
